// File: rtl/pipe_register_chain.sv
// pipe_register_chain: DEPTH back-to-back register stages with per-stage valid bits
// and a valid/ready handshake at both ends. Each stage advances on its own, so
// bubbles collapse and an output stall back-fills the chain.
module pipe_register_chain #(
    parameter int              WIDTH       = 8,
    parameter int              DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_load;
    logic             w_downFree;
    logic             w_inXfer;
    logic             w_outXfer;

    // Walk from the output stage back to the input, deciding which stages move this cycle.
    always_comb begin
        w_adv      = '0;
        w_downFree = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_adv[k]   = r_valid[k] && w_downFree;
            w_downFree = !r_valid[k] || w_adv[k];
        end
    end

    // Stage k loads whenever the stage feeding it advances; stage 0 is fed by the input port.
    always_comb begin
        w_load    = '0;
        w_load[0] = w_inXfer;
        for (int k = 1; k < DEPTH; k++) begin
            w_load[k] = w_adv[k-1];
        end
    end

    assign in_ready  = !rst && !flush && w_downFree;
    assign w_inXfer  = in_valid && in_ready;
    assign w_outXfer = w_adv[DEPTH-1];

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign count     = r_count;

    // Valid bits and occupancy count; flush drops every in-flight word at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_load | (r_valid & ~w_adv);
            if (w_inXfer && !w_outXfer) begin
                r_count <= r_count + CW'(1);
            end else if (!w_inXfer && w_outXfer) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Data registers change only when their stage accepts a word, otherwise they hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= RESET_VALUE;
            end
        end else begin
            if (w_load[0]) begin
                r_data[0] <= in_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_register_chain.sv
// tb_pipe_register_chain: scoreboard bench for pipe_register_chain. The reference model
// treats the chain as an ordered queue of words, each stamped with the clock edge at
// which it was accepted; a word becomes visible once it has aged DEPTH-1 edges.
module tb_pipe_register_chain;

    localparam int         WIDTH       = 8;
    localparam int         DEPTH       = 3;
    localparam int         CW          = $clog2(DEPTH+1);
    localparam logic [7:0] RESET_VALUE = 8'h5A;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [CW-1:0] count;

    typedef struct {
        logic [7:0] data;
        int         acceptEdge;
    } entry_t;

    entry_t     sbQueue[$];
    int         checks = 0;
    int         errors = 0;
    int         edgeCnt = 0;
    bit         acceptPending = 0;
    bit         flushPending = 0;
    logic [7:0] acceptData = '0;

    pipe_register_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_VALUE(RESET_VALUE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge and hold them until the next one.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit rdy, input bit fl);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Compare the DUT against the model mid-cycle, then pop delivered words and note what the coming edge will accept.
    task automatic monitorStep();
        int size;
        bit expInReady;
        bit expOutValid;
        size = sbQueue.size();
        if (rst) begin
            checkOutput("rstInReady", 32'(in_ready), 32'(0));
            checkOutput("rstOutValid", 32'(out_valid), 32'(0));
            checkOutput("rstCount", 32'(count), 32'(0));
            checkOutput("rstOutData", 32'(out_data), 32'(RESET_VALUE));
            acceptPending = 0;
            flushPending  = 0;
        end else begin
            expInReady  = !flush && (size < DEPTH || out_ready);
            expOutValid = (size > 0) && (edgeCnt - sbQueue[0].acceptEdge >= DEPTH - 1);
            checkOutput("count", 32'(count), 32'(size));
            checkOutput("inReady", 32'(in_ready), 32'(expInReady));
            checkOutput("outValid", 32'(out_valid), 32'(expOutValid));
            if (expOutValid) begin
                checkOutput("outData", 32'(out_data), 32'(sbQueue[0].data));
                if (out_ready) begin
                    void'(sbQueue.pop_front());
                end
            end
            acceptPending = in_valid && expInReady;
            acceptData    = in_data;
            flushPending  = flush;
        end
    endtask

    // Monitor: samples on the falling edge, well away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            monitorStep();
        end
    end

    // Model update at each rising edge: stamp accepted words, drop everything on flush or reset.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                sbQueue.delete();
                acceptPending = 0;
                flushPending  = 0;
            end else begin
                edgeCnt++;
                if (flushPending) begin
                    sbQueue.delete();
                end else if (acceptPending) begin
                    sbQueue.push_back('{acceptData, edgeCnt});
                end
                acceptPending = 0;
                flushPending  = 0;
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        checkOutput("initOutData", 32'(out_data), 32'(RESET_VALUE));
        checkOutput("initCount", 32'(count), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("postRstInReady", 32'(in_ready), 32'(1));

        // Latency: single word, then a back-to-back stream
        applyStimulus(1, 8'h11, 1, 0);
        repeat (4) applyStimulus(0, 8'h00, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1, 8'(i), 1, 0);
            if (i > DEPTH) checkOutput("streamCount", 32'(count), 32'(DEPTH));
        end
        repeat (4) applyStimulus(0, 8'h00, 1, 0);

        // Backpressure: fill, confirm full, then drain
        applyStimulus(1, 8'hA1, 0, 0);
        applyStimulus(1, 8'hA2, 0, 0);
        applyStimulus(1, 8'hA3, 0, 0);
        checkOutput("bpCount", 32'(count), 32'(3));
        checkOutput("bpOutData", 32'(out_data), 32'(8'hA1));
        checkOutput("bpInReady", 32'(in_ready), 32'(0));
        applyStimulus(1, 8'hA4, 0, 0);
        checkOutput("bpHeld", 32'(out_data), 32'(8'hA1));
        repeat (3) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("bpDrained", 32'(count), 32'(0));

        // Bubble collapse
        applyStimulus(1, 8'hB1, 0, 0);
        repeat (2) applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(1, 8'hB2, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("bubbleCount", 32'(count), 32'(2));
        checkOutput("bubbleOutData", 32'(out_data), 32'(8'hB1));

        // Flush with a competing input word
        in_valid  = 1'b1;
        in_data   = 8'hCC;
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        checkOutput("flushInReady", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flushCount", 32'(count), 32'(0));
        checkOutput("flushOutValid", 32'(out_valid), 32'(0));
        repeat (4) applyStimulus(0, 8'h00, 1, 0);

        // Full pass-through: simultaneous input and output transfer
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'hD0 + i), 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 8'(8'hE0 + i), 1, 0);
            checkOutput("passCount", 32'(count), 32'(3));
        end

        // Asynchronous reset with the chain full
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("preRstCount", 32'(count), 32'(3));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstOutValid", 32'(out_valid), 32'(0));
        checkOutput("asyncRstCount", 32'(count), 32'(0));
        checkOutput("asyncRstOutData", 32'(out_data), 32'(RESET_VALUE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 3);
        end
        repeat (8) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("finalCount", 32'(count), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
